// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle add/sub/and/or plus an iterative shift-add multiplier.
// Optional ALU_MUL_EARLY_EXIT_EN ends the multiply once the remaining multiplier bits are zero.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e            state_q;
    logic              valid_q;
    logic              zero_q;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  mult_q;
    logic [CntW-1:0]   cnt_q;

    logic              accept;
    logic              is_mul;
    logic              mul_last;
    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH-1:0]  acc_sum;

    assign ready_o = (state_q == StIdle) | ((state_q == StDone) & ready_i);
    assign accept  = valid_i & ready_o;
    assign is_mul  = (ALUCtrl_i == 3'b110);

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign Zero_o  = zero_q;

    // Unlisted codes (000/101/111) fall back to add.
    always_comb begin
        alu_res = data1_i + data2_i;
        unique case (ALUCtrl_i)
            3'b010:  alu_res = data1_i - data2_i;
            3'b011:  alu_res = data1_i & data2_i;
            3'b100:  alu_res = data1_i | data2_i;
            default: alu_res = data1_i + data2_i;
        endcase
    end

    assign acc_sum = acc_q + (mult_q[0] ? mcand_q : '0);

`ifdef ALU_MUL_EARLY_EXIT_EN
    assign mul_last = (cnt_q == CntW'(1)) || ((mult_q >> 1) == '0);
`else
    assign mul_last = (cnt_q == CntW'(1));
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            data_q  <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (is_mul) begin
                            acc_q   <= '0;
                            mcand_q <= data1_i;
                            mult_q  <= data2_i;
                            cnt_q   <= CntW'(WIDTH);
                            valid_q <= 1'b0;
                            state_q <= StMul;
                        end else begin
                            data_q  <= alu_res;
                            zero_q  <= (alu_res == '0);
                            valid_q <= 1'b1;
                            state_q <= StDone;
                        end
                    end else if ((state_q == StDone) && ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StMul: begin
                    acc_q   <= acc_sum;
                    mcand_q <= mcand_q << 1;
                    mult_q  <= mult_q >> 1;
                    cnt_q   <= cnt_q - CntW'(1);
                    if (mul_last) begin
                        data_q  <= acc_sum;
                        zero_q  <= (acc_sum == '0);
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32); follows ALU_MUL_EARLY_EXIT_EN if set.
module tb_alu_exec_unit;

    localparam int unsigned W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [2:0]    ALUCtrl_i = 3'b000;
    logic [W-1:0]  data1_i = '0;
    logic [W-1:0]  data2_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [W-1:0]  data_o;
    logic          Zero_o;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .Zero_o    (Zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Edges after the accept edge before valid_o is seen.
    function automatic int exp_mul_edges(input logic [W-1:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
        int hi;
        hi = 0;
        for (int i = 0; i < int'(W); i++) if (b[i]) hi = i;
        return hi + 1;
`else
        return int'(W);
`endif
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one op with ready_i=1 and wait (bounded) for valid_o; no checking here.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int edges, output int busy);
        valid_i   = 1'b1;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        ready_i   = 1'b1;
        step();
        valid_i = 1'b0;
        data1_i = 32'hDEAD_BEEF;
        data2_i = 32'h1234_5678;
        ALUCtrl_i = 3'b011;
        edges = 0;
        busy  = 0;
        while (!valid_o && edges < 200) begin
            if (!ready_o) busy++;
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        step();
        step();
        n_vec++;
        if (valid_o !== 1'b0 || data_o !== '0 || Zero_o !== 1'b0 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset: valid=%b data=%h zero=%b ready=%b, want 0 0 0 1",
                     valid_o, data_o, Zero_o, ready_o);
        end
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_add();
        int e, b;
        n_vec++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL add_ready: ready_o=%b want 1", ready_o);
        end
        run_op(3'b001, 32'd5, 32'd7, e, b);
        n_vec++;
        if (e !== 0 || data_o !== 32'd12 || Zero_o !== 1'b0) begin
            n_err++;
            $display("FAIL add: edges=%0d data=%h zero=%b, want 0 0000000c 0", e, data_o, Zero_o);
        end
        step();
        n_vec++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 32'd12) begin
            n_err++;
            $display("FAIL add_idle: valid=%b ready=%b data=%h, want 0 1 0000000c",
                     valid_o, ready_o, data_o);
        end
    endtask

    task automatic test_sub();
        int e, b;
        run_op(3'b010, 32'd9, 32'd9, e, b);
        n_vec++;
        if (e !== 0 || data_o !== 32'd0 || Zero_o !== 1'b1) begin
            n_err++;
            $display("FAIL sub_eq: edges=%0d data=%h zero=%b, want 0 00000000 1", e, data_o, Zero_o);
        end
        step();
        run_op(3'b010, 32'd3, 32'd5, e, b);
        n_vec++;
        if (data_o !== 32'hFFFF_FFFE || Zero_o !== 1'b0) begin
            n_err++;
            $display("FAIL sub_wrap: data=%h zero=%b, want fffffffe 0", data_o, Zero_o);
        end
        step();
    endtask

    task automatic test_mul();
        int e, b;
        run_op(3'b110, 32'hFFFF_FFFF, 32'd3, e, b);
        n_vec++;
        if (e !== exp_mul_edges(32'd3) || data_o !== 32'hFFFF_FFFD || Zero_o !== 1'b0) begin
            n_err++;
            $display("FAIL mul_wrap: edges=%0d data=%h zero=%b, want %0d fffffffd 0",
                     e, data_o, Zero_o, exp_mul_edges(32'd3));
        end
        n_vec++;
        if (b !== exp_mul_edges(32'd3)) begin
            n_err++;
            $display("FAIL mul_busy: ready_o low %0d cycles, want %0d", b, exp_mul_edges(32'd3));
        end
        step();
        run_op(3'b110, 32'd6, 32'd7, e, b);
        n_vec++;
        if (e !== exp_mul_edges(32'd7) || data_o !== 32'd42) begin
            n_err++;
            $display("FAIL mul_6x7: edges=%0d data=%h, want %0d 0000002a",
                     e, data_o, exp_mul_edges(32'd7));
        end
        step();
    endtask

    task automatic test_back_to_back();
        valid_i   = 1'b1;
        ALUCtrl_i = 3'b011;
        data1_i   = 32'h0000_F0F0;
        data2_i   = 32'h0000_FF00;
        ready_i   = 1'b0;
        step();
        // The or request sits pending while the and result is held.
        ALUCtrl_i = 3'b100;
        data1_i   = 32'h1;
        data2_i   = 32'h2;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (valid_o !== 1'b1 || data_o !== 32'h0000_F000 || ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: valid=%b data=%h ready=%b, want 1 0000f000 0",
                         i, valid_o, data_o, ready_o);
            end
            step();
        end
        ready_i = 1'b1;
        #1;
        n_vec++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: ready_o=%b want 1", ready_o);
        end
        step();
        valid_i = 1'b0;
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 32'd3 || Zero_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_or: valid=%b data=%h zero=%b, want 1 00000003 0",
                     valid_o, data_o, Zero_o);
        end
        step();
        n_vec++;
        if (valid_o !== 1'b0 || data_o !== 32'd3) begin
            n_err++;
            $display("FAIL b2b_idle: valid=%b data=%h, want 0 00000003", valid_o, data_o);
        end
    endtask

    task automatic test_reset_mid_mul();
        int e, b;
        valid_i   = 1'b1;
        ALUCtrl_i = 3'b110;
        data1_i   = 32'd6;
        data2_i   = 32'h8000_0007;
        ready_i   = 1'b1;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 9; i++) step();
        n_vec++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_mul_busy: valid=%b ready=%b, want 0 0", valid_o, ready_o);
        end
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        n_vec++;
        if (valid_o !== 1'b0 || data_o !== '0 || ready_o !== 1'b1 || Zero_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_mul_reset: valid=%b data=%h ready=%b zero=%b, want 0 0 1 0",
                     valid_o, data_o, ready_o, Zero_o);
        end
        // Aborted multiply must never surface a result.
        for (int i = 0; i < 30; i++) begin
            if (valid_o !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL mid_mul_ghost: valid_o=%b at cycle %0d, want 0", valid_o, i);
                break;
            end
            step();
        end
        run_op(3'b001, 32'd1, 32'd1, e, b);
        n_vec++;
        if (e !== 0 || data_o !== 32'd2) begin
            n_err++;
            $display("FAIL post_reset_add: edges=%0d data=%h, want 0 00000002", e, data_o);
        end
        step();
    endtask

    task automatic test_early_exit();
        int e, b;
        run_op(3'b110, 32'd6, 32'd3, e, b);
        n_vec++;
        if (e !== exp_mul_edges(32'd3) || data_o !== 32'd18) begin
            n_err++;
            $display("FAIL mul_6x3: edges=%0d data=%h, want %0d 00000012",
                     e, data_o, exp_mul_edges(32'd3));
        end
        step();
        run_op(3'b110, 32'd6, 32'd0, e, b);
        n_vec++;
        if (e !== exp_mul_edges(32'd0) || data_o !== 32'd0 || Zero_o !== 1'b1) begin
            n_err++;
            $display("FAIL mul_6x0: edges=%0d data=%h zero=%b, want %0d 00000000 1",
                     e, data_o, Zero_o, exp_mul_edges(32'd0));
        end
        step();
        run_op(3'b111, 32'd4, 32'd4, e, b);
        n_vec++;
        if (e !== 0 || data_o !== 32'd8) begin
            n_err++;
            $display("FAIL op111: edges=%0d data=%h, want 0 00000008", e, data_o);
        end
        step();
        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, e, b);
        n_vec++;
        if (data_o !== 32'd0 || Zero_o !== 1'b1) begin
            n_err++;
            $display("FAIL op101: data=%h zero=%b, want 00000000 1", data_o, Zero_o);
        end
        step();
        run_op(3'b000, 32'd100, 32'd23, e, b);
        n_vec++;
        if (data_o !== 32'd123) begin
            n_err++;
            $display("FAIL op000: data=%h, want 0000007b", data_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_early_exit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
